// File: rtl/rv_pl_pkg.sv
// Shared definitions for the rv_pl hazard/forwarding controller.
// Holds the forward-select encodings, the hazard FSM state type and default widths.
package rv_pl_pkg;

  localparam int RA_W_DEF = 5;

  localparam logic [1:0] FD_RF = 2'b00;
  localparam logic [1:0] FD_M  = 2'b10;
  localparam logic [1:0] FD_W  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LD_WAIT  = 2'd1,
    ST_MDU_BUSY = 2'd2
  } hz_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rv_pl_fwd_sel.sv
// Forward-select for one E-stage operand: M result beats W result; x0 is never forwarded.
module rv_pl_fwd_sel
  import rv_pl_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] src,
  input  logic [RA_W-1:0] m_rf_a3,
  input  logic            m_we_rf,
  input  logic [RA_W-1:0] w_rf_a3,
  input  logic            w_we_rf,
  output logic [1:0]      sel
);

  always_comb begin
    sel = FD_RF;
    if (src != '0 && m_we_rf && m_rf_a3 == src) begin
      sel = FD_M;
    end else if (src != '0 && w_we_rf && w_rf_a3 == src) begin
      sel = FD_W;
    end
  end

endmodule

// File: rtl/rv_pl_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage rv_pl core: stall FSM for multi-cycle loads
// and the MDU handshake. Optional perf counters are built when HAZARD_PERF_EN is defined.
module rv_pl_hazard_ctrl
  import rv_pl_pkg::*;
#(
  parameter int RA_W     = RA_W_DEF,
  parameter int DMEM_LAT = 1,
  parameter int MDU_TMO  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] D_rf_a1,
  input  logic [RA_W-1:0] D_rf_a2,
  input  logic [RA_W-1:0] E_rf_a1,
  input  logic [RA_W-1:0] E_rf_a2,
  input  logic [RA_W-1:0] E_rf_a3,
  input  logic            E_is_load,
  input  logic            E_is_mdu,
  input  logic            E_pcsrc,
  input  logic [RA_W-1:0] M_rf_a3,
  input  logic            M_we_rf,
  input  logic            M_is_load,
  input  logic [RA_W-1:0] W_rf_a3,
  input  logic            W_we_rf,
  input  logic            mdu_done,
  output logic            F_stall,
  output logic            D_stall,
  output logic            E_stall,
  output logic            M_stall,
  output logic            D_flush,
  output logic            E_flush,
  output logic            W_flush,
  output logic [1:0]      E_fd_A,
  output logic [1:0]      E_fd_B,
  output logic            mdu_start,
  output logic            err_mdu_tmo
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     perf_stall_cyc,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(max_int(DMEM_LAT, MDU_TMO)) + 1;
  localparam logic [CNT_W-1:0] LD_INIT  = CNT_W'((DMEM_LAT > 1) ? DMEM_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MDU_TMO - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  hz_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic             ld_exit_reg, ld_exit_next;
  logic             load_use, ld_enter;

  logic [RA_W-1:0]  e_src  [2];
  logic [1:0]       fd_raw [2];

  assign e_src[0] = E_rf_a1;
  assign e_src[1] = E_rf_a2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      rv_pl_fwd_sel #(.RA_W(RA_W)) u_fwd (
        .src     (e_src[gi]),
        .m_rf_a3 (M_rf_a3),
        .m_we_rf (M_we_rf),
        .w_rf_a3 (W_rf_a3),
        .w_we_rf (W_we_rf),
        .sel     (fd_raw[gi])
      );
    end
  endgenerate

  assign E_fd_A      = rst ? FD_RF : fd_raw[0];
  assign E_fd_B      = rst ? FD_RF : fd_raw[1];
  assign err_mdu_tmo = err_reg;

  assign load_use = E_is_load && (E_rf_a3 != '0) &&
                    ((E_rf_a3 == D_rf_a1) || (E_rf_a3 == D_rf_a2));
  // The load just released from LD_WAIT is still visible in M for one cycle; do not re-enter for it.
  assign ld_enter = M_is_load && (DMEM_LAT > 1) && !ld_exit_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    err_next     = err_reg;
    ld_exit_next = 1'b0;
    F_stall      = 1'b0;
    D_stall      = 1'b0;
    E_stall      = 1'b0;
    M_stall      = 1'b0;
    D_flush      = 1'b0;
    E_flush      = 1'b0;
    W_flush      = 1'b0;
    mdu_start    = 1'b0;
    if (rst) begin
      D_flush = 1'b1;
      E_flush = 1'b1;
      W_flush = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (E_pcsrc) begin
            D_flush = 1'b1;
            E_flush = 1'b1;
          end else if (load_use) begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            E_flush = 1'b1;
          end
          if (ld_enter) begin
            state_next = ST_LD_WAIT;
            cnt_next   = LD_INIT;
          end else if (E_is_mdu && !E_pcsrc) begin
            mdu_start  = 1'b1;
            F_stall    = 1'b1;
            D_stall    = 1'b1;
            E_stall    = 1'b1;
            E_flush    = 1'b1;
            state_next = ST_MDU_BUSY;
            cnt_next   = '0;
          end
        end
        ST_LD_WAIT: begin
          F_stall = 1'b1;
          D_stall = 1'b1;
          E_stall = 1'b1;
          M_stall = 1'b1;
          W_flush = 1'b1;
          if (cnt_reg == '0) begin
            state_next   = ST_IDLE;
            ld_exit_next = 1'b1;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        ST_MDU_BUSY: begin
          // Release E on done or timeout so the E->M register captures whatever the MDU holds.
          if (mdu_done) begin
            state_next = ST_IDLE;
          end else if (cnt_reg == TMO_LAST) begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            E_stall = 1'b1;
            E_flush = 1'b1;
            if (cnt_reg != CNT_SAT) begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      ld_exit_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
      ld_exit_reg <= ld_exit_next;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_reg, perf_flush_reg;
  logic        pc_flush;

  assign pc_flush       = !rst && (state_reg == ST_IDLE) && E_pcsrc;
  assign perf_stall_cyc = perf_stall_reg;
  assign perf_flush_cnt = perf_flush_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (F_stall) perf_stall_reg <= perf_stall_reg + 32'd1;
      if (pc_flush) perf_flush_reg <= perf_flush_reg + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv_pl_hazard_ctrl.sv
// Directed bench for rv_pl_hazard_ctrl (DMEM_LAT=3, MDU_TMO=8); perf checks under HAZARD_PERF_EN.
module tb_rv_pl_hazard_ctrl;
  import rv_pl_pkg::*;

  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic rst;
  logic [RA_W-1:0] D_rf_a1, D_rf_a2, E_rf_a1, E_rf_a2, E_rf_a3, M_rf_a3, W_rf_a3;
  logic E_is_load, E_is_mdu, E_pcsrc, M_we_rf, M_is_load, W_we_rf, mdu_done;
  logic F_stall, D_stall, E_stall, M_stall, D_flush, E_flush, W_flush;
  logic [1:0] E_fd_A, E_fd_B;
  logic mdu_start, err_mdu_tmo;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_start;

  always #5 clk = ~clk;

  rv_pl_hazard_ctrl #(.RA_W(RA_W), .DMEM_LAT(3), .MDU_TMO(8)) dut (
    .clk(clk), .rst(rst),
    .D_rf_a1(D_rf_a1), .D_rf_a2(D_rf_a2),
    .E_rf_a1(E_rf_a1), .E_rf_a2(E_rf_a2), .E_rf_a3(E_rf_a3),
    .E_is_load(E_is_load), .E_is_mdu(E_is_mdu), .E_pcsrc(E_pcsrc),
    .M_rf_a3(M_rf_a3), .M_we_rf(M_we_rf), .M_is_load(M_is_load),
    .W_rf_a3(W_rf_a3), .W_we_rf(W_we_rf), .mdu_done(mdu_done),
    .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall),
    .D_flush(D_flush), .E_flush(E_flush), .W_flush(W_flush),
    .E_fd_A(E_fd_A), .E_fd_B(E_fd_B),
    .mdu_start(mdu_start), .err_mdu_tmo(err_mdu_tmo)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] stalls();
    return {28'd0, F_stall, D_stall, E_stall, M_stall};
  endfunction

  function automatic logic [31:0] flushes();
    return {29'd0, D_flush, E_flush, W_flush};
  endfunction

  task automatic clear_inputs();
    D_rf_a1 = '0; D_rf_a2 = '0; E_rf_a1 = '0; E_rf_a2 = '0; E_rf_a3 = '0;
    M_rf_a3 = '0; W_rf_a3 = '0;
    E_is_load = 1'b0; E_is_mdu = 1'b0; E_pcsrc = 1'b0;
    M_we_rf = 1'b0; M_is_load = 1'b0; W_we_rf = 1'b0; mdu_done = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Reset: forwarding forced to RF even with a live M match, all flushes up.
    nxt();
    M_we_rf = 1'b1; M_rf_a3 = 5'd5; E_rf_a1 = 5'd5;
    smp();
    check("rst_stall", stalls(), 32'h0);
    check("rst_flush", flushes(), 32'h7);
    check("rst_fdA", E_fd_A, FD_RF);
    check("rst_start", mdu_start, 0);
    check("rst_err", err_mdu_tmo, 0);

    nxt();
    rst = 1'b0; clear_inputs();
    smp();
    check("idle_stall", stalls(), 32'h0);
    check("idle_flush", flushes(), 32'h0);

    // Forwarding: M over W, W alone, x0 never forwarded.
    nxt();
    M_we_rf = 1'b1; M_rf_a3 = 5'd5; W_we_rf = 1'b1; W_rf_a3 = 5'd5;
    E_rf_a1 = 5'd5; E_rf_a2 = 5'd7;
    smp();
    check("fwd_m_prio", E_fd_A, 2'b10);
    check("fwd_none", E_fd_B, 2'b00);
    nxt();
    M_rf_a3 = 5'd6; E_rf_a2 = 5'd6;
    smp();
    check("fwd_w", E_fd_A, 2'b01);
    check("fwd_m", E_fd_B, 2'b10);
    nxt();
    M_we_rf = 1'b0; M_rf_a3 = 5'd5;
    smp();
    check("fwd_m_nowe", E_fd_A, 2'b01);
    nxt();
    M_we_rf = 1'b1; M_rf_a3 = 5'd0; W_rf_a3 = 5'd0; E_rf_a1 = 5'd0;
    smp();
    check("fwd_x0", E_fd_A, 2'b00);
    clear_inputs();

    // Load-use, then the same with a taken branch, then an x0 destination.
    nxt();
    E_is_load = 1'b1; E_rf_a3 = 5'd3; D_rf_a2 = 5'd3;
    smp();
    check("lu_stall", stalls(), 32'hC);
    check("lu_flush", flushes(), 32'h2);
    nxt();
    E_pcsrc = 1'b1;
    smp();
    check("lu_pc_stall", stalls(), 32'h0);
    check("lu_pc_flush", flushes(), 32'h6);
    nxt();
    E_pcsrc = 1'b0; E_rf_a3 = 5'd0; D_rf_a2 = 5'd0;
    smp();
    check("lu_x0_stall", stalls(), 32'h0);
    clear_inputs();

    // Multi-cycle load: detect cycle, two LD_WAIT cycles (pcsrc masked), then idle.
    nxt();
    M_is_load = 1'b1;
    smp();
    check("ld_det_stall", stalls(), 32'h0);
    nxt();
    M_is_load = 1'b0; E_pcsrc = 1'b1;
    smp();
    check("ld_w1_stall", stalls(), 32'hF);
    check("ld_w1_flush", flushes(), 32'h1);
    nxt();
    E_pcsrc = 1'b0;
    smp();
    check("ld_w2_stall", stalls(), 32'hF);
    check("ld_w2_flush", flushes(), 32'h1);
    nxt();
    smp();
    check("ld_exit_stall", stalls(), 32'h0);
    check("ld_exit_flush", flushes(), 32'h0);

    // MDU with done on cycle 5: five stalled cycles, one start pulse.
    n_start = 0;
    for (int c = 0; c <= 5; c++) begin
      nxt();
      E_is_mdu = 1'b1;
      E_pcsrc  = (c == 2);
      mdu_done = (c == 5);
      smp();
      if (mdu_start) n_start++;
      check($sformatf("mdu_c%0d_stall", c), stalls(), (c < 5) ? 32'hE : 32'h0);
      check($sformatf("mdu_c%0d_flush", c), flushes(), (c < 5) ? 32'h2 : 32'h0);
    end
    check("mdu_start_cnt", n_start, 1);
    nxt();
    E_is_mdu = 1'b0; E_pcsrc = 1'b0; mdu_done = 1'b1;
    smp();
    check("mdu_idle_done", stalls(), 32'h0);
    nxt();
    mdu_done = 1'b0;
    smp();
    check("mdu_idle_ign", stalls(), 32'h0);
    check("mdu_idle_start", mdu_start, 0);

    // MDU timeout: start plus seven busy cycles stalled, release on the eighth busy cycle.
    n_start = 0;
    for (int c = 0; c <= 8; c++) begin
      nxt();
      E_is_mdu = 1'b1;
      smp();
      if (mdu_start) n_start++;
      check($sformatf("tmo_c%0d_stall", c), stalls(), (c < 8) ? 32'hE : 32'h0);
      check($sformatf("tmo_c%0d_err", c), err_mdu_tmo, 0);
    end
    check("tmo_start_cnt", n_start, 1);
    for (int c = 9; c <= 10; c++) begin
      nxt();
      E_is_mdu = 1'b0;
      smp();
      check($sformatf("tmo_c%0d_err", c), err_mdu_tmo, 1);
      check($sformatf("tmo_c%0d_stall", c), stalls(), 32'h0);
    end
`ifdef HAZARD_PERF_EN
    check("perf_stall", perf_stall_cyc, 32'd16);
    check("perf_flush", perf_flush_cnt, 32'd1);
`endif

    // Reset in the middle of MDU_BUSY.
    for (int c = 0; c <= 2; c++) begin
      nxt();
      E_is_mdu = 1'b1;
      smp();
    end
    check("rmdu_busy", stalls(), 32'hE);
    nxt();
    rst = 1'b1;
    smp();
    check("rmdu_rst_stall", stalls(), 32'h0);
    check("rmdu_rst_flush", flushes(), 32'h7);
    nxt();
    rst = 1'b0; E_is_mdu = 1'b0;
    smp();
    check("rmdu_idle_stall", stalls(), 32'h0);
    check("rmdu_idle_flush", flushes(), 32'h0);
    check("rmdu_err", err_mdu_tmo, 0);
`ifdef HAZARD_PERF_EN
    check("rmdu_perf_stall", perf_stall_cyc, 32'd0);
    check("rmdu_perf_flush", perf_flush_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
